// File: rtl/fc_pkg.sv
// Shared types, default widths and saturating arithmetic for the fc_argmax_layer slice.
// Latency: none (package only).
// Backpressure: not applicable.
package fc_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_FRAC_BITS = 14;
  localparam int DEF_ACC_W     = 32;

  // Wide working width so the sum of two in-range operands never wraps before clamping.
  localparam int SAT_W = 64;
  typedef logic signed [SAT_W-1:0] sat_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_CMP,
    S_FIN
  } fc_state_t;

  // Adds two sign-extended operands and clamps the result to a signed 'width'-bit range.
  function automatic sat_t sat_add(input sat_t a, input sat_t b, input int unsigned width);
    sat_t sum;
    sat_t hi;
    sat_t lo;
    sum = a + b;
    hi  = (sat_t'(1) <<< (width - 1)) - sat_t'(1);
    lo  = -hi - sat_t'(1);
    if (sum > hi)      return hi;
    else if (sum < lo) return lo;
    else               return sum;
  endfunction

endpackage

// File: rtl/fc_mac.sv
// Fixed-point multiply-accumulate: (x*w)>>>FRAC_BITS added to a saturating accumulator.
// Latency: 1 cycle from enabled operands to updated acc; clr wins over en.
// Backpressure: none; operands are consumed on every enabled cycle.
module fc_mac
  import fc_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  parameter int ACC_W     = DEF_ACC_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] w,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [2*DATA_W-1:0] prod_sh;
  sat_t                       term;
  sat_t                       acc_nxt;

  // Full-width product, arithmetic rescale, then clamp the running sum into ACC_W.
  always_comb begin
    prod    = x * w;
    prod_sh = prod >>> FRAC_BITS;
    term    = sat_t'(prod_sh);
    acc_nxt = sat_add(sat_t'(acc), term, ACC_W);
  end

  // Accumulator register; clear starts a new neuron.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= ACC_W'(acc_nxt);
  end

endmodule

// File: rtl/fc_argmax_layer.sv
// Fully connected output layer with running argmax; optional bias add under FC_BIAS_EN.
// Latency: done pulses N_OUT*(N_IN+2)+1 cycles after the accepted start.
// Backpressure: none; SRAM data is consumed exactly one cycle after each registered address.
module fc_argmax_layer
  import fc_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int N_IN      = 784,
  parameter int N_OUT     = 10,
  parameter int ADDR_W    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          x_base,
  input  logic [ADDR_W-1:0]          w_base,
  input  logic [ADDR_W-1:0]          b_base,
  output logic [ADDR_W-1:0]          x_addr,
  output logic [ADDR_W-1:0]          w_addr,
  output logic [ADDR_W-1:0]          b_addr,
  input  logic [DATA_W-1:0]          x_data,
  input  logic [DATA_W-1:0]          w_data,
  input  logic [DATA_W-1:0]          b_data,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(N_OUT)-1:0]   class_idx,
  output logic signed [ACC_W-1:0]    max_score
);

  localparam int IDX_W = $clog2(N_OUT);
  localparam int K_W   = $clog2(N_IN) + 1;
  localparam logic [ADDR_W-1:0]       ROW_STRIDE = ADDR_W'(N_IN);
  localparam logic signed [ACC_W-1:0] ACC_MIN    = {1'b1, {(ACC_W-1){1'b0}}};

  fc_state_t                state, state_nxt;
  logic [K_W-1:0]           k;
  logic [IDX_W-1:0]         j;
  logic [IDX_W-1:0]         arg;
  logic [ADDR_W-1:0]        x_base_q;
  logic [ADDR_W-1:0]        w_row;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  best;
  logic signed [ACC_W-1:0]  score;
  logic                     last_k;
  logic                     last_j;
  logic                     better;

  fc_mac #(
    .DATA_W   (DATA_W),
    .FRAC_BITS(FRAC_BITS),
    .ACC_W    (ACC_W)
  ) u_mac (
    .clk  (clk),
    .reset(reset),
    .clr  (state == S_CLR),
    .en   (state == S_RUN),
    .x    ($signed(x_data)),
    .w    ($signed(w_data)),
    .acc  (acc)
  );

`ifdef FC_BIAS_EN
  // b_addr is set on entry to CLR, so b_data is stable by CMP.
  assign score = ACC_W'(sat_add(sat_t'(acc), sat_t'($signed(b_data)), ACC_W));

  // Bias pointer: one entry per neuron.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_addr <= '0;
    end else if (state == S_IDLE && start) begin
      b_addr <= b_base;
    end else if (state == S_CMP && !last_j) begin
      b_addr <= b_addr + ADDR_W'(1);
    end
  end
`else
  logic unused_bias;
  assign unused_bias = ^{b_data, b_base};
  assign score       = acc;
  assign b_addr      = '0;
`endif

  assign last_k = (k == K_W'(N_IN - 1));
  assign last_j = (j == IDX_W'(N_OUT - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state, status outputs and strict-greater argmax compare.
  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    better    = (score > best);
    case (state)
      S_IDLE: if (start) state_nxt = S_CLR;
      S_CLR:  state_nxt = S_RUN;
      S_RUN:  if (last_k) state_nxt = S_CMP;
      S_CMP:  state_nxt = last_j ? S_FIN : S_CLR;
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Counters, address generation and argmax tracking. Results are loaded on the
  // final compare so class_idx/max_score are already valid in the done cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k         <= '0;
      j         <= '0;
      arg       <= '0;
      best      <= ACC_MIN;
      x_base_q  <= '0;
      w_row     <= '0;
      x_addr    <= '0;
      w_addr    <= '0;
      class_idx <= '0;
      max_score <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            x_base_q  <= x_base;
            w_row     <= w_base;
            x_addr    <= x_base;
            w_addr    <= w_base;
            j         <= '0;
            arg       <= '0;
            best      <= ACC_MIN;
            class_idx <= '0;
            max_score <= '0;
          end
        end
        S_CLR: begin
          k      <= '0;
          x_addr <= x_addr + ADDR_W'(1);
          w_addr <= w_addr + ADDR_W'(1);
        end
        S_RUN: begin
          k      <= k + K_W'(1);
          x_addr <= x_addr + ADDR_W'(1);
          w_addr <= w_addr + ADDR_W'(1);
        end
        S_CMP: begin
          if (better) begin
            best <= score;
            arg  <= j;
          end
          if (last_j) begin
            class_idx <= better ? j : arg;
            max_score <= better ? score : best;
          end else begin
            j      <= j + IDX_W'(1);
            x_addr <= x_base_q;
            w_row  <= w_row + ROW_STRIDE;
            w_addr <= w_row + ROW_STRIDE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_argmax_layer.sv
module tb_fc_argmax_layer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start1 = 1'b0;
  logic        start2 = 1'b0;
  logic [7:0]  x_base = '0, w_base = '0, b_base = '0;

  logic [7:0]  x_a1, w_a1, b_a1, x_a2, w_a2, b_a2;
  logic [15:0] x_d1, w_d1, b_d1, x_d2, w_d2, b_d2;
  logic        busy1, done1, busy2, done2;
  logic [1:0]  idx1;
  logic [0:0]  idx2;
  logic [31:0] score1;
  logic [15:0] score2;

  logic [15:0] x_mem [256];
  logic [15:0] w_mem [256];
  logic [15:0] b_mem [256];

  int     n_checks = 0;
  int     n_pass   = 0;
  int     sel      = 0;
  int     edges    = 0;
  bit     in_flight = 1'b0;
  int     exp_lat  = 0;
  int     exp_idx  = 0;
  longint exp_score = 0;

  always #5 clk = ~clk;

  fc_argmax_layer #(
    .DATA_W(16), .FRAC_BITS(14), .ACC_W(32), .N_IN(4), .N_OUT(3), .ADDR_W(8)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .x_base(x_base), .w_base(w_base), .b_base(b_base),
    .x_addr(x_a1), .w_addr(w_a1), .b_addr(b_a1),
    .x_data(x_d1), .w_data(w_d1), .b_data(b_d1),
    .busy(busy1), .done(done1), .class_idx(idx1), .max_score(score1)
  );

  fc_argmax_layer #(
    .DATA_W(16), .FRAC_BITS(14), .ACC_W(16), .N_IN(8), .N_OUT(2), .ADDR_W(8)
  ) dut2 (
    .clk(clk), .reset(reset), .start(start2),
    .x_base(x_base), .w_base(w_base), .b_base(b_base),
    .x_addr(x_a2), .w_addr(w_a2), .b_addr(b_a2),
    .x_data(x_d2), .w_data(w_d2), .b_data(b_d2),
    .busy(busy2), .done(done2), .class_idx(idx2), .max_score(score2)
  );

  // Synchronous SRAM models: data one cycle after address.
  always @(posedge clk) begin
    x_d1 <= x_mem[x_a1]; w_d1 <= w_mem[w_a1]; b_d1 <= b_mem[b_a1];
    x_d2 <= x_mem[x_a2]; w_d2 <= w_mem[w_a2]; b_d2 <= b_mem[b_a2];
  end

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Reference: plain fixed-point dot products with clamping, then strict argmax.
  function automatic void model(input int nin, input int nout, input int accw,
                                input int xb, input int wb, input int bb);
    longint hi, lo, acc, best, xv, wv;
    int idx;
    hi = (longint'(1) <<< (accw - 1)) - 1;
    lo = -hi - 1;
    best = lo;
    idx = 0;
    for (int j = 0; j < nout; j++) begin
      acc = 0;
      for (int k = 0; k < nin; k++) begin
        xv = longint'($signed(x_mem[(xb + k) & 255]));
        wv = longint'($signed(w_mem[(wb + j*nin + k) & 255]));
        acc = acc + ((xv * wv) >>> 14);
        if (acc > hi) acc = hi;
        if (acc < lo) acc = lo;
      end
`ifdef FC_BIAS_EN
      acc = acc + longint'($signed(b_mem[(bb + j) & 255]));
      if (acc > hi) acc = hi;
      if (acc < lo) acc = lo;
`endif
      if (acc > best) begin
        best = acc;
        idx  = j;
      end
    end
    exp_idx   = idx;
    exp_score = best;
  endfunction

  // Compare process: every cycle, check busy/done against the run in flight,
  // and on done check latency and results against the model.
  always @(negedge clk) begin
    bit     c_done, c_busy, o_done;
    int     c_idx;
    longint c_score;
    if (!reset) begin
      c_done  = (sel == 1) ? done2 : done1;
      c_busy  = (sel == 1) ? busy2 : busy1;
      o_done  = (sel == 1) ? done1 : done2;
      c_idx   = (sel == 1) ? int'(idx2) : int'(idx1);
      c_score = (sel == 1) ? longint'($signed(score2)) : longint'($signed(score1));
      if (in_flight) edges++;
      check("busy", longint'(c_busy), longint'(in_flight));
      check("other_done_quiet", longint'(o_done), 0);
      if (c_done) begin
        if (in_flight) begin
          check("done_latency", edges, exp_lat);
          check("model_class_idx", c_idx, exp_idx);
          check("model_max_score", c_score, exp_score);
          in_flight = 1'b0;
        end else begin
          check("spurious_done", longint'(c_done), 0);
        end
      end
    end
  end

  task automatic fill_w(input int base, input int n, input logic [15:0] v);
    for (int i = 0; i < n; i++) w_mem[(base + i) & 255] = v;
  endtask

  task automatic fill_x(input int base, input int n, input logic [15:0] v);
    for (int i = 0; i < n; i++) x_mem[(base + i) & 255] = v;
  endtask

  task automatic launch(input int s, input int xb, input int wb, input int bb, input int lat);
    if (s == 0) model(4, 3, 32, xb, wb, bb);
    else        model(8, 2, 16, xb, wb, bb);
    @(negedge clk);
    #1;
    sel     = s;
    exp_lat = lat;
    x_base  = xb[7:0];
    w_base  = wb[7:0];
    b_base  = bb[7:0];
    start1  = (s == 0);
    start2  = (s == 1);
    edges   = 0;
    in_flight = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic finish_run(input string name, input int lit_idx, input longint lit_score);
    int n;
    n = 0;
    while (in_flight && n < 200) begin
      @(negedge clk);
      n++;
    end
    #1;
    check({name, "_done_seen"}, longint'(in_flight), 0);
    if (sel == 1) begin
      check({name, "_class_idx"}, int'(idx2), lit_idx);
      check({name, "_max_score"}, longint'($signed(score2)), lit_score);
    end else begin
      check({name, "_class_idx"}, int'(idx1), lit_idx);
      check({name, "_max_score"}, longint'($signed(score1)), lit_score);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      x_mem[i] = '0; w_mem[i] = '0; b_mem[i] = '0;
    end

    // Reset state.
    #2;
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_class_idx", idx1, 0);
    check("rst_max_score", score1, 0);
    check("rst_x_addr", x_a1, 0);
    check("rst_w_addr", w_a1, 0);
    check("rst_b_addr", b_a1, 0);
    check("rst_busy2", busy2, 0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;

    // x = 1.0 everywhere; only row 1 has 0.5 weights -> 4 * 0.5 = 2.0 = 0x8000.
    fill_x(8'h10, 4, 16'h4000);
    fill_w(8'h40, 4, 16'h0000);
    fill_w(8'h44, 4, 16'h2000);
    fill_w(8'h48, 4, 16'h0000);
    launch(0, 8'h10, 8'h40, 8'h80, 19);
    finish_run("basic", 1, 64'h8000);

    // Tie between rows 0 and 2 (0x4000 each), row 1 lower: lower index wins.
    fill_w(8'h40, 4, 16'h1000);
    fill_w(8'h44, 4, 16'h0800);
    fill_w(8'h48, 4, 16'h1000);
    launch(0, 8'h10, 8'h40, 8'h80, 19);
    finish_run("tie", 0, 64'h4000);

    // All-negative scores, weight matrix wrapping past address 0xFF.
    fill_w(8'hFA, 4, 16'hFC00);
    fill_w(8'hFE, 4, 16'hFE00);
    fill_w(8'h02, 4, 16'hF800);
    launch(0, 8'h10, 8'hFA, 8'h80, 19);
    finish_run("negative", 1, -64'sh800);

    // Zero weights; biases only matter when the bias feature is built in.
    fill_w(8'h40, 12, 16'h0000);
    b_mem[8'h80] = 16'd5;
    b_mem[8'h81] = 16'd9;
    b_mem[8'h82] = 16'd2;
    launch(0, 8'h10, 8'h40, 8'h80, 19);
`ifdef FC_BIAS_EN
    finish_run("bias", 1, 9);
    check("bias_b_addr", b_a1, 8'h82);
`else
    finish_run("bias", 0, 0);
    check("bias_b_addr", b_a1, 0);
`endif

    // Saturation with 16-bit accumulator: each term is 0xFFFC, sum clamps at 0x7FFF.
    fill_x(8'h20, 8, 16'h7FFF);
    fill_w(8'h60, 8, 16'h7FFF);
    fill_w(8'h68, 8, 16'h0000);
    launch(1, 8'h20, 8'h60, 8'h80, 21);
    finish_run("saturate", 0, 64'h7FFF);

    // Reset pulsed mid-RUN: everything clears at once and no done follows.
    fill_w(8'h40, 4, 16'h0000);
    fill_w(8'h44, 4, 16'h2000);
    fill_w(8'h48, 4, 16'h0000);
    launch(0, 8'h10, 8'h40, 8'h80, 19);
    repeat (3) @(negedge clk);
    #1;
    check("pre_reset_busy", busy1, 1);
    reset = 1'b1;
    in_flight = 1'b0;
    #1;
    check("midrst_busy", busy1, 0);
    check("midrst_done", done1, 0);
    check("midrst_class_idx", idx1, 0);
    check("midrst_max_score", score1, 0);
    check("midrst_x_addr", x_a1, 0);
    check("midrst_w_addr", w_a1, 0);
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (30) @(negedge clk);

    // Restart after the aborted run completes normally.
    launch(0, 8'h10, 8'h40, 8'h80, 19);
    finish_run("after_reset", 1, 64'h8000);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
